// File: rtl/oup_ulpi_regctl.sv
// oup_ulpi_regctl: ULPI PHY register read/write controller with abort, retry and timeout handling.
// Define OUP_ULPI_EXTREG_EN to enable extended (addr > 8'h3F) register access via the EXTA phase.
module oup_ulpi_regctl #(
    parameter int NXT_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    input  logic       tx_busy,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_data_oe,
    output logic       ulpi_stp
);
    localparam int CW = $clog2(NXT_TIMEOUT + 1);
`ifdef OUP_ULPI_EXTREG_EN
    localparam int AW = 8;
`else
    localparam int AW = 6;
`endif

    typedef enum logic [3:0] {
        IDLE,
        CMD,
`ifdef OUP_ULPI_EXTREG_EN
        EXTA,
`endif
        WDATA,
        STP,
        TURN1,
        RDATA,
        TURN2,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          pend, wr_q, err_q, fail, drive, stp, waiting, tmo, accept;
    logic [AW-1:0] addr_q;
    logic [7:0]    wdata_q, rdata_q, data_o;
    logic [5:0]    cmd_addr;

    assign req_ready    = rst_n && state == IDLE && !pend && !ulpi_dir && !tx_busy;
    assign accept       = req_valid && req_ready;
    assign tmo          = cnt == CW'(NXT_TIMEOUT);
    assign rsp_valid    = state == DONE;
    assign rsp_err      = state == DONE && err_q;
    assign ulpi_data_o  = data_o;
    // The PHY owns the bus whenever dir is high, so oe is gated without waiting for the FSM.
    assign ulpi_data_oe = drive && !ulpi_dir;
    assign ulpi_stp     = stp;
`ifdef OUP_ULPI_EXTREG_EN
    assign cmd_addr = |addr_q[7:6] ? 6'h2F : addr_q[5:0];
`else
    assign cmd_addr = addr_q;
`endif

    always_comb begin
        state_n = state;
        fail    = 1'b0;
        drive   = 1'b0;
        stp     = 1'b0;
        waiting = 1'b0;
        data_o  = 8'h00;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef OUP_ULPI_EXTREG_EN
                    state_n = CMD;
`else
                    state_n = |req_addr[7:6] ? DONE : CMD;
                    fail    = |req_addr[7:6];
`endif
                end else if (pend && !ulpi_dir && !tx_busy) begin
                    state_n = CMD;
                end
            end
            CMD: begin
                drive   = 1'b1;
                waiting = 1'b1;
                data_o  = {1'b1, !wr_q, cmd_addr};
                if (ulpi_dir) begin
                    state_n = IDLE;
                end else if (ulpi_nxt) begin
`ifdef OUP_ULPI_EXTREG_EN
                    state_n = |addr_q[7:6] ? EXTA : wr_q ? WDATA : TURN1;
`else
                    state_n = wr_q ? WDATA : TURN1;
`endif
                end else if (tmo) begin
                    state_n = DONE;
                    fail    = 1'b1;
                end
            end
`ifdef OUP_ULPI_EXTREG_EN
            EXTA: begin
                drive   = 1'b1;
                waiting = 1'b1;
                data_o  = addr_q;
                if (ulpi_dir) begin
                    state_n = IDLE;
                end else if (ulpi_nxt) begin
                    state_n = wr_q ? WDATA : TURN1;
                end else if (tmo) begin
                    state_n = DONE;
                    fail    = 1'b1;
                end
            end
`endif
            WDATA: begin
                drive   = 1'b1;
                waiting = 1'b1;
                data_o  = wdata_q;
                if (ulpi_dir) begin
                    state_n = IDLE;
                end else if (ulpi_nxt) begin
                    state_n = STP;
                end else if (tmo) begin
                    state_n = DONE;
                    fail    = 1'b1;
                end
            end
            STP: begin
                drive   = 1'b1;
                stp     = 1'b1;
                state_n = DONE;
            end
            TURN1: begin
                waiting = 1'b1;
                if (ulpi_dir) begin
                    state_n = RDATA;
                end else if (tmo) begin
                    state_n = DONE;
                    fail    = 1'b1;
                end
            end
            // nxt here flags a PHY receive abort; the pending request is retried from IDLE.
            RDATA: state_n = ulpi_nxt ? IDLE : TURN2;
            TURN2: begin
                waiting = 1'b1;
                if (!ulpi_dir) begin
                    state_n = DONE;
                end else if (tmo) begin
                    state_n = DONE;
                    fail    = 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pend      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            err_q     <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state || !waiting) ? '0 : cnt + 1'b1;
            if (accept) begin
                pend    <= 1'b1;
                wr_q    <= req_write;
                addr_q  <= req_addr[AW-1:0];
                wdata_q <= req_wdata;
            end else if (state == DONE) begin
                pend <= 1'b0;
            end
            if (state == RDATA && !ulpi_nxt) rdata_q <= ulpi_data_i;
            if (state_n == DONE && state != DONE) begin
                err_q     <= fail;
                rsp_rdata <= (fail || wr_q) ? 8'h00 : rdata_q;
            end
        end
    end
endmodule

// File: tb/tb_oup_ulpi_regctl.sv
// tb_oup_ulpi_regctl: directed self-checking bench for the ULPI register controller.
// Extended-register expectations follow OUP_ULPI_EXTREG_EN.
module tb_oup_ulpi_regctl;
    logic       clk = 1'b0, rst_n = 1'b1;
    logic       req_valid = 1'b0, req_write = 1'b0, tx_busy = 1'b0, ulpi_dir = 1'b0, ulpi_nxt = 1'b0;
    logic [7:0] req_addr = 8'h00, req_wdata = 8'h00, ulpi_data_i = 8'h00;
    logic       req_ready, rsp_valid, rsp_err, ulpi_data_oe, ulpi_stp;
    logic [7:0] rsp_rdata, ulpi_data_o;
    int tests = 0, fails = 0, nrsp = 0;

    always #5 clk = ~clk;
    always @(negedge clk) if (rsp_valid) nrsp++;

    oup_ulpi_regctl #(.NXT_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .tx_busy(tx_busy), .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt),
        .ulpi_data_i(ulpi_data_i), .ulpi_data_o(ulpi_data_o),
        .ulpi_data_oe(ulpi_data_oe), .ulpi_stp(ulpi_stp)
    );

    task step;
        @(posedge clk);
        #1;
    endtask

    task issue(input logic w, input logic [7:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    task test_reset;
        #1 rst_n = 1'b0;
        req_valid = 1'b1;
        #2;
        tests++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, ulpi_data_oe, ulpi_data_o, ulpi_stp} !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", {req_ready, rsp_valid, rsp_err, rsp_rdata, ulpi_data_oe, ulpi_data_o, ulpi_stp});
        end
        req_valid = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b want 1", req_ready); end
        tx_busy = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b0) begin fails++; $display("FAIL ready_tx_busy: got %b want 0", req_ready); end
        tx_busy  = 1'b0;
        ulpi_dir = 1'b1;
        #1;
        tests++;
        if ({req_ready, ulpi_data_oe} !== 2'b00) begin fails++; $display("FAIL ready_dir: got %b want 00", {req_ready, ulpi_data_oe}); end
        ulpi_dir = 1'b0;
        step();
    endtask

    task test_write;
        int n0;
        n0 = nrsp;
        issue(1'b1, 8'h16, 8'hA5);
        ulpi_nxt = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL wr_accept: got %b want 1", req_ready); end
        step(); req_valid = 1'b0; #1;
        tests++;
        if ({ulpi_data_oe, ulpi_data_o, ulpi_stp} !== {1'b1, 8'h96, 1'b0}) begin fails++; $display("FAIL wr_cmd: got %h want %h", {ulpi_data_oe, ulpi_data_o, ulpi_stp}, {1'b1, 8'h96, 1'b0}); end
        step(); #1;
        tests++;
        if ({ulpi_data_oe, ulpi_data_o, ulpi_stp} !== {1'b1, 8'hA5, 1'b0}) begin fails++; $display("FAIL wr_data: got %h want %h", {ulpi_data_oe, ulpi_data_o, ulpi_stp}, {1'b1, 8'hA5, 1'b0}); end
        step(); #1;
        tests++;
        if ({ulpi_data_oe, ulpi_data_o, ulpi_stp} !== {1'b1, 8'h00, 1'b1}) begin fails++; $display("FAIL wr_stp: got %h want %h", {ulpi_data_oe, ulpi_data_o, ulpi_stp}, {1'b1, 8'h00, 1'b1}); end
        ulpi_nxt = 1'b0;
        step(); #1;
        tests++;
        if ({rsp_valid, rsp_err, ulpi_stp, ulpi_data_oe} !== 4'b1000) begin fails++; $display("FAIL wr_rsp: got %b want 1000", {rsp_valid, rsp_err, ulpi_stp, ulpi_data_oe}); end
        step(); #1;
        tests++;
        if ({rsp_valid, nrsp - n0} !== {1'b0, 32'd1}) begin fails++; $display("FAIL wr_single_rsp: valid %b count %0d want 0/1", rsp_valid, nrsp - n0); end
    endtask

    task test_read;
        issue(1'b0, 8'h00, 8'h00);
        #1;
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL rd_accept: got %b want 1", req_ready); end
        step(); req_valid = 1'b0; ulpi_nxt = 1'b1; #1;
        tests++;
        if ({ulpi_data_oe, ulpi_data_o, ulpi_stp} !== {1'b1, 8'hC0, 1'b0}) begin fails++; $display("FAIL rd_cmd: got %h want %h", {ulpi_data_oe, ulpi_data_o, ulpi_stp}, {1'b1, 8'hC0, 1'b0}); end
        step(); ulpi_nxt = 1'b0; ulpi_dir = 1'b1; #1;
        tests++;
        if ({ulpi_data_oe, ulpi_stp} !== 2'b00) begin fails++; $display("FAIL rd_turn1: got %b want 00", {ulpi_data_oe, ulpi_stp}); end
        step(); ulpi_data_i = 8'h24;
        step(); ulpi_data_i = 8'h00;
        step(); ulpi_dir = 1'b0; #1;
        tests++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_early_rsp: got %b want 0", rsp_valid); end
        step(); #1;
        tests++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h24}) begin fails++; $display("FAIL rd_rsp: got %h want %h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 8'h24}); end
        step(); #1;
        tests++;
        if ({rsp_valid, rsp_rdata} !== {1'b0, 8'h24}) begin fails++; $display("FAIL rd_hold: got %h want %h", {rsp_valid, rsp_rdata}, {1'b0, 8'h24}); end
    endtask

    task test_timeout;
        issue(1'b0, 8'h01, 8'h00);
        step(); req_valid = 1'b0; #1;
        tests++;
        if ({ulpi_data_oe, ulpi_data_o, ulpi_stp} !== {1'b1, 8'hC1, 1'b0}) begin fails++; $display("FAIL to_cmd: got %h want %h", {ulpi_data_oe, ulpi_data_o, ulpi_stp}, {1'b1, 8'hC1, 1'b0}); end
        repeat (4) step();
        #1;
        tests++;
        if ({rsp_valid, ulpi_data_oe} !== 2'b01) begin fails++; $display("FAIL to_early: got %b want 01", {rsp_valid, ulpi_data_oe}); end
        step(); #1;
        tests++;
        if ({rsp_valid, rsp_err, ulpi_data_oe, rsp_rdata} !== {3'b110, 8'h00}) begin fails++; $display("FAIL to_rsp: got %h want %h", {rsp_valid, rsp_err, ulpi_data_oe, rsp_rdata}, {3'b110, 8'h00}); end
        step();
    endtask

    task test_abort;
        int n0;
        n0 = nrsp;
        issue(1'b1, 8'h0A, 8'h5C);
        ulpi_nxt = 1'b1;
        step(); req_valid = 1'b0; #1;
        tests++;
        if ({ulpi_data_oe, ulpi_data_o, ulpi_stp} !== {1'b1, 8'h8A, 1'b0}) begin fails++; $display("FAIL ab_cmd: got %h want %h", {ulpi_data_oe, ulpi_data_o, ulpi_stp}, {1'b1, 8'h8A, 1'b0}); end
        step(); ulpi_dir = 1'b1; #1;
        tests++;
        if ({ulpi_data_oe, ulpi_stp} !== 2'b00) begin fails++; $display("FAIL ab_gate: got %b want 00", {ulpi_data_oe, ulpi_stp}); end
        step(); ulpi_nxt = 1'b0; #1;
        tests++;
        if ({ulpi_data_oe, ulpi_stp, req_ready, rsp_valid} !== 4'b0000) begin fails++; $display("FAIL ab_idle: got %b want 0000", {ulpi_data_oe, ulpi_stp, req_ready, rsp_valid}); end
        step(); ulpi_dir = 1'b0; #1;
        tests++;
        if (req_ready !== 1'b0) begin fails++; $display("FAIL ab_pending: got %b want 0", req_ready); end
        step(); ulpi_nxt = 1'b1; #1;
        tests++;
        if ({ulpi_data_oe, ulpi_data_o, ulpi_stp} !== {1'b1, 8'h8A, 1'b0}) begin fails++; $display("FAIL ab_reissue: got %h want %h", {ulpi_data_oe, ulpi_data_o, ulpi_stp}, {1'b1, 8'h8A, 1'b0}); end
        step(); #1;
        tests++;
        if ({ulpi_data_oe, ulpi_data_o, ulpi_stp} !== {1'b1, 8'h5C, 1'b0}) begin fails++; $display("FAIL ab_data: got %h want %h", {ulpi_data_oe, ulpi_data_o, ulpi_stp}, {1'b1, 8'h5C, 1'b0}); end
        step(); ulpi_nxt = 1'b0; #1;
        tests++;
        if ({ulpi_data_oe, ulpi_data_o, ulpi_stp} !== {1'b1, 8'h00, 1'b1}) begin fails++; $display("FAIL ab_stp: got %h want %h", {ulpi_data_oe, ulpi_data_o, ulpi_stp}, {1'b1, 8'h00, 1'b1}); end
        step(); step(); step(); #1;
        tests++;
        if (nrsp - n0 !== 1) begin fails++; $display("FAIL ab_rsp_count: got %0d want 1", nrsp - n0); end
    endtask

    task test_ext;
        issue(1'b1, 8'h80, 8'h3C);
        ulpi_nxt = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL ext_accept: got %b want 1", req_ready); end
        step(); req_valid = 1'b0; #1;
`ifdef OUP_ULPI_EXTREG_EN
        tests++;
        if ({ulpi_data_oe, ulpi_data_o, ulpi_stp} !== {1'b1, 8'hAF, 1'b0}) begin fails++; $display("FAIL ext_cmd: got %h want %h", {ulpi_data_oe, ulpi_data_o, ulpi_stp}, {1'b1, 8'hAF, 1'b0}); end
        step(); #1;
        tests++;
        if ({ulpi_data_oe, ulpi_data_o, ulpi_stp} !== {1'b1, 8'h80, 1'b0}) begin fails++; $display("FAIL ext_addr: got %h want %h", {ulpi_data_oe, ulpi_data_o, ulpi_stp}, {1'b1, 8'h80, 1'b0}); end
        step(); #1;
        tests++;
        if ({ulpi_data_oe, ulpi_data_o, ulpi_stp} !== {1'b1, 8'h3C, 1'b0}) begin fails++; $display("FAIL ext_data: got %h want %h", {ulpi_data_oe, ulpi_data_o, ulpi_stp}, {1'b1, 8'h3C, 1'b0}); end
        step(); ulpi_nxt = 1'b0; #1;
        tests++;
        if ({ulpi_data_oe, ulpi_data_o, ulpi_stp} !== {1'b1, 8'h00, 1'b1}) begin fails++; $display("FAIL ext_stp: got %h want %h", {ulpi_data_oe, ulpi_data_o, ulpi_stp}, {1'b1, 8'h00, 1'b1}); end
        step(); #1;
        tests++;
        if ({rsp_valid, rsp_err} !== 2'b10) begin fails++; $display("FAIL ext_rsp: got %b want 10", {rsp_valid, rsp_err}); end
`else
        tests++;
        if ({rsp_valid, rsp_err, ulpi_data_oe, ulpi_stp} !== 4'b1100) begin fails++; $display("FAIL ext_illegal: got %b want 1100", {rsp_valid, rsp_err, ulpi_data_oe, ulpi_stp}); end
        ulpi_nxt = 1'b0;
        step(); #1;
        tests++;
        if ({rsp_valid, ulpi_data_oe, req_ready} !== 3'b001) begin fails++; $display("FAIL ext_after: got %b want 001", {rsp_valid, ulpi_data_oe, req_ready}); end
`endif
        step();
    endtask

    task test_mid_reset;
        int n0;
        issue(1'b0, 8'h02, 8'h00);
        step(); req_valid = 1'b0; ulpi_nxt = 1'b1;
        step(); ulpi_nxt = 1'b0;
        n0 = nrsp;
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, ulpi_data_oe, ulpi_data_o, ulpi_stp} !== 20'h0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got %h want 0", {req_ready, rsp_valid, rsp_err, rsp_rdata, ulpi_data_oe, ulpi_data_o, ulpi_stp});
        end
        step(); rst_n = 1'b1;
        repeat (4) step();
        #1;
        tests++;
        if ({nrsp - n0, req_ready, ulpi_data_oe} !== {32'd0, 2'b10}) begin fails++; $display("FAIL mid_reset_after: rsp %0d ready %b oe %b want 0 1 0", nrsp - n0, req_ready, ulpi_data_oe); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_abort();
        test_ext();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/oup_ulpi_regctl.md
OUP_ULPI_REGCTL -- requirements
Module: oup_ulpi_regctl

Interface
REQ-001 SHALL have parameter NXT_TIMEOUT, default 255, the maximum number of cycles to wait for nxt or dir before failing an access.
REQ-002 SHALL have ports in this order:
- clk  in  1  ULPI 60 MHz clock; all logic on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  register access request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = register write, 0 = register read.
- req_addr  in  8  PHY register address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data; valid with rsp_valid.
- rsp_err  out  1  timeout or illegal address; valid with rsp_valid.
- tx_busy  in  1  packet transmitter owns the ULPI bus.
- ulpi_dir  in  1  PHY bus direction.
- ulpi_nxt  in  1  PHY throttle.
- ulpi_data_i  in  8  ULPI data from the PHY.
- ulpi_data_o  out  8  ULPI data to the PHY.
- ulpi_data_oe  out  1  link drives ulpi_data_o.
- ulpi_stp  out  1  ULPI stop.

Function
REQ-003 SHALL assert req_ready only when the state is IDLE, ulpi_dir=0 and tx_busy=0, and SHALL register addr, wdata and write on acceptance.
REQ-004 SHALL implement the states IDLE, CMD, EXTA, WDATA, STP, TURN1, RDATA, TURN2 and DONE.
REQ-005 SHALL drive ulpi_data_o={2'b10,addr[5:0]} for a write and {2'b11,addr[5:0]} for a read in CMD, with ulpi_data_oe=1.
REQ-006 SHALL transition from CMD on ulpi_nxt=1 as follows: extended address to EXTA; otherwise write to WDATA; otherwise read to TURN1.
REQ-007 SHALL, in WDATA, drive wdata with oe=1 and go to STP on ulpi_nxt=1.
REQ-008 SHALL, in STP, drive ulpi_stp=1 and data 8'h00 for exactly one cycle, then go to DONE.
REQ-009 SHALL, in TURN1, set oe=0, and on ulpi_dir=1 go to RDATA.
REQ-010 SHALL, in RDATA, capture ulpi_data_i into rsp_rdata and go to TURN2.
REQ-011 SHALL, in TURN2, wait for ulpi_dir=0, then go to DONE.
REQ-012 SHALL, in DONE, assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-013 SHALL give a write with nxt held high: accept at cycle 0, CMD at 1, WDATA at 2, STP at 3, rsp_valid at 4.
REQ-014 SHALL abort a command if ulpi_dir rises while in CMD, EXTA or WDATA: oe=0 next cycle, stp not asserted, request retained and reissued from CMD once ulpi_dir=0 and tx_busy=0, with no response issued for the aborted attempt.
REQ-015 SHALL treat ulpi_nxt=1 in RDATA as a PHY receive abort: discard the data, wait for ulpi_dir=0, then retry from CMD.
REQ-016 SHALL count cycles spent waiting in CMD, EXTA, WDATA, TURN1 and TURN2, reset the count on each state change, and on reaching NXT_TIMEOUT go to DONE with rsp_err=1, oe=0 and rsp_rdata=0.
REQ-017 SHALL never assert ulpi_data_oe while ulpi_dir=1, combinationally gated so that oe=0 in the same cycle.
REQ-018 SHALL hold rsp_rdata until the next rsp_valid.

Reset
REQ-019 SHALL, while rst_n=0, hold state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, ulpi_data_o=0, ulpi_data_oe=0, ulpi_stp=0 and the timeout counter at 0.
REQ-020 SHALL, on reset mid-access, release the bus (oe=0, stp=0) asynchronously, drop the pending request and issue no response.

Configuration
REQ-021 SHALL, with OUP_ULPI_EXTREG_EN defined and req_addr>8'h3F, send TX CMD address 6'h2F, then in EXTA drive req_addr with oe=1 and advance on ulpi_nxt=1 per REQ-006, with no extra cycle for addresses<=8'h3F.
REQ-022 SHALL, with OUP_ULPI_EXTREG_EN undefined, accept req_addr>8'h3F without touching the bus, give rsp_valid=1 and rsp_err=1 one cycle after acceptance, and omit EXTA entirely.

Verification
REQ-023 SHALL cover a write of addr 8'h16, data 8'hA5 with nxt high -> data_o 8'h96, 8'hA5, then stp=1 and data 8'h00 at cycle 3; rsp_valid at cycle 4 with rsp_err=0.
REQ-024 SHALL cover a read of 8'h00 with nxt at cycle 1, dir high cycles 2-4, data_i=8'h24 at cycle 3 -> data_o 8'hC0; rsp_rdata=8'h24 and rsp_valid after dir falls.
REQ-025 SHALL cover dir rising during the WDATA of a write to 8'h0A -> oe=0 with no stp; after dir falls, CMD 8'h8A is reissued and exactly one rsp_valid occurs.
REQ-026 SHALL cover nxt held low with NXT_TIMEOUT=4 -> rsp_valid with rsp_err=1 five cycles after CMD entry and oe=0.
REQ-027 SHALL cover a write of 8'h80 -> with OUP_ULPI_EXTREG_EN: data_o 8'hAF, 8'h80, wdata, then stp; without it: rsp_err=1, one cycle after acceptance, with oe never asserted.
REQ-028 SHALL cover rst_n low during a read's TURN1 -> all outputs 0 immediately, state IDLE and no rsp_valid.
